// File: rtl/fifo_wr_adapter.sv
// ============================================================================
// Module      : fifo_wr_adapter
// Description : Write-side skid adapter. It turns a valid/ready stream into
//               FIFO wr_en/full writes. s_ready comes from a flop.
//               Optional write counter: define FIFO_WR_ADAPTER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_adapter #(
    parameter int DATA_WIDTH = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic [1:0]            level,
    output logic [15:0]           wr_cnt
);

    // State bit 1 is the output-register valid; bit 0 is the skid valid.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_s_ready;
    logic [DATA_WIDTH-1:0] r_out_q;
    logic [DATA_WIDTH-1:0] r_skid_q;
    logic                  w_push;
    logic                  w_pop;

    assign w_push = s_valid & r_s_ready;
    // Gating with out_v keeps an unknown full flag out of the state.
    assign w_pop  = r_state[1] & ~fifo_full_i;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
            ST_ONE: begin
                if (w_push && !w_pop)      w_state_nxt = ST_TWO;
                else if (!w_push && w_pop) w_state_nxt = ST_EMPTY;
            end
            ST_TWO:   if (w_pop) w_state_nxt = ST_ONE;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= ST_EMPTY;
            r_s_ready <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_s_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk) begin
        case (r_state)
            ST_EMPTY: if (w_push) r_out_q <= s_data;
            ST_ONE: begin
                if (w_push && w_pop)  r_out_q  <= s_data;
                else if (w_push)      r_skid_q <= s_data;
            end
            ST_TWO:   if (w_pop) r_out_q <= r_skid_q;
            default: ;
        endcase
    end

    assign s_ready        = r_s_ready;
    assign fifo_wr_en_o   = w_pop;
    assign fifo_wr_data_o = r_out_q;
    assign level          = {1'b0, r_state[1]} + {1'b0, r_state[0]};

`ifdef FIFO_WR_ADAPTER_CNT_EN
    logic [15:0] r_wr_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_wr_cnt <= 16'd0;
        else if (w_pop && (r_wr_cnt != 16'hFFFF))
            r_wr_cnt <= r_wr_cnt + 16'd1;
    end

    assign wr_cnt = r_wr_cnt;
`else
    assign wr_cnt = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_adapter.sv
// ============================================================================
// Module      : tb_fifo_wr_adapter
// Description : Directed and scoreboard bench for fifo_wr_adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_adapter;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          fifo_full_i = 1'b0;
    logic          fifo_wr_en_o;
    logic [DW-1:0] fifo_wr_data_o;
    logic [1:0]    level;
    logic [15:0]   wr_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    bit sb_on    = 1'b0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    fifo_wr_adapter #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .level          (level),
        .wr_cnt         (wr_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Apply inputs just after the rising edge, then move to the falling edge for sampling.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic full);
        @(posedge clk);
        #1;
        s_valid     = v;
        s_data      = d;
        fifo_full_i = full;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; s_valid = 1'b0; fifo_full_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Writes are matched against older acceptances before this cycle's push is queued.
    always @(negedge clk) begin
        if (sb_on) begin
            if (fifo_wr_en_o) begin
                if (exp_q.size() == 0) check("sb_extra_write", 32'd1, 32'd0);
                else                   check("sb_data", fifo_wr_data_o, exp_q.pop_front());
            end
            if (s_valid && s_ready) exp_q.push_back(s_data);
        end
    end

    initial begin
        // Reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready", s_ready, 1);
        check("rst_level", level, 0);
        check("rst_wr_en", fifo_wr_en_o, 0);
        check("rst_wr_cnt", wr_cnt, 0);

        // Streaming 0x01..0x08
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, DW'(i + 1), 1'b0);
            check("stream_wr_en", fifo_wr_en_o, (i >= 1 && i <= 8) ? 1 : 0);
            check("stream_s_ready", s_ready, 1);
            if (i >= 1 && i <= 8) begin
                check("stream_data", fifo_wr_data_o, i);
                check("stream_level", level, 1);
            end
        end
        check("stream_idle_level", level, 0);

        // Backpressure
        drive(1'b1, 8'hA0, 1'b1);
        check("bp0_wr_en", fifo_wr_en_o, 0);
        drive(1'b1, 8'hA1, 1'b1);
        check("bp1_level", level, 1);
        check("bp1_s_ready", s_ready, 1);
        check("bp1_wr_en", fifo_wr_en_o, 0);
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 8'hA2, 1'b1);
            check("bp2_level", level, 2);
            check("bp2_s_ready", s_ready, 0);
            check("bp2_wr_en", fifo_wr_en_o, 0);
        end
        drive(1'b1, 8'hA2, 1'b0);
        check("bp4_wr_en", fifo_wr_en_o, 1);
        check("bp4_data", fifo_wr_data_o, 8'hA0);
        check("bp4_s_ready", s_ready, 0);
        drive(1'b1, 8'hA2, 1'b0);
        check("bp5_wr_en", fifo_wr_en_o, 1);
        check("bp5_data", fifo_wr_data_o, 8'hA1);
        check("bp5_s_ready", s_ready, 1);
        drive(1'b0, 8'h00, 1'b0);
        check("bp6_wr_en", fifo_wr_en_o, 1);
        check("bp6_data", fifo_wr_data_o, 8'hA2);
        check("bp6_level", level, 1);
        drive(1'b0, 8'h00, 1'b0);
        check("bp7_level", level, 0);
        check("bp7_wr_en", fifo_wr_en_o, 0);

        // Reset while holding two words
        drive(1'b1, 8'hB0, 1'b1);
        drive(1'b1, 8'hB1, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check("mid_pre_level", level, 2);
        @(posedge clk);
        #1 rst = 1'b0; fifo_full_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_level", level, 0);
        check("mid_s_ready", s_ready, 1);
        check("mid_wr_en", fifo_wr_en_o, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 8'h00, 1'b0);
            check("mid_no_write", fifo_wr_en_o, 0);
        end

        // Full toggling every cycle with random valid
        sb_on = 1'b1;
        for (int c = 0; c < 10000; c++)
            drive(1'($urandom_range(0, 1)), DW'($urandom), c[0]);
        for (int k = 0; k < 4; k++)
            drive(1'b0, 8'h00, 1'b0);
        sb_on = 1'b0;
        check("sb_leftover", exp_q.size(), 0);
        check("sb_drained_level", level, 0);

`ifdef FIFO_WR_ADAPTER_CNT_EN
        do_reset();
        check("cnt_after_reset", wr_cnt, 0);
        for (int k = 0; k < 5; k++) drive(1'b1, DW'(k), 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check("cnt_five", wr_cnt, 5);
        for (int k = 0; k < 65540; k++) drive(1'b1, DW'(k), 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check("cnt_saturated", wr_cnt, 16'hFFFF);
        do_reset();
        check("cnt_cleared", wr_cnt, 0);
`else
        check("cnt_off_after_random", wr_cnt, 0);
        for (int k = 0; k < 5; k++) drive(1'b1, DW'(k), 1'b0);
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        check("cnt_off_after_writes", wr_cnt, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
